// File: rtl/scan_sequencer.sv
// scan_sequencer: column scan sequencer with prescaled dwell, post-switch blanking and frame-start pulse
module scan_sequencer #(
  parameter int DIV_VALUE = 4,
  parameter int BLANK_CYCLES = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [2:0] last_index,
  output logic [2:0] select,
  output logic [7:0] column_n,
  output logic       blank,
  output logic       frame_start
);
  localparam logic [15:0] div_last = 16'(DIV_VALUE - 1);
  localparam logic [15:0] blank_init = 16'(BLANK_CYCLES);
  logic [15:0] prescaler;
  logic [15:0] blank_cnt;
  logic        tick;
  logic        wrap;
  always_comb begin
    tick = enable && prescaler == div_last;
    wrap = select >= last_index;
    blank = blank_cnt != 16'd0 || !enable || !reset_n;
    column_n = blank ? 8'hFF : ~(8'd1 << select);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prescaler   <= 16'd0;
      select      <= 3'd0;
      blank_cnt   <= blank_init;
      frame_start <= 1'b0;
    end else begin
      prescaler   <= tick || !enable ? 16'd0 : prescaler + 16'd1;
      select      <= tick ? (wrap ? 3'd0 : select + 3'd1) : select;
      blank_cnt   <= tick ? blank_init : enable && blank_cnt != 16'd0 ? blank_cnt - 16'd1 : blank_cnt;
      frame_start <= tick && wrap;
    end
  end
endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 The module SHALL have parameter DIV_VALUE, default 4, meaning the number of clock cycles each channel is held (legal 2..65535).
REQ-002 The module SHALL have parameter BLANK_CYCLES, default 1, meaning the number of blanked cycles after each channel change (legal 0..DIV_VALUE-1).
REQ-003 The module SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port enable, input, 1 bit: run/pause of the scan.
REQ-006 The module SHALL have port last_index, input, 3 bits: highest channel index scanned (0..7).
REQ-007 The module SHALL have port select, output, 3 bits: current channel index, driven straight into the select input of an 8-to-1 data mux.
REQ-008 The module SHALL have port column_n, output, 8 bits: active-low one-hot enable of the current channel.
REQ-009 The module SHALL have port blank, output, 1 bit: high while column_n is forced to all ones.
REQ-010 The module SHALL have port frame_start, output, 1 bit: one-cycle pulse when select wraps to 0.

Function
REQ-011 The module SHALL hold a prescaler counter (16 bits) that increments by 1 per cycle while enable=1 and reaches at most DIV_VALUE-1.
REQ-012 The module SHALL generate tick when prescaler=DIV_VALUE-1 and enable=1; on that edge prescaler returns to 0.
REQ-013 On tick, select SHALL advance: next = 0 if select >= last_index, else select+1; on any other cycle select SHALL hold.
REQ-014 A last_index change mid-scan SHALL take effect at the next tick only; if select > new last_index, that tick SHALL wrap select to 0.
REQ-015 frame_start SHALL be a registered pulse, high for exactly the one cycle after the edge on which a tick loaded select with 0 by wrapping (including last_index=0, which pulses every tick).
REQ-016 A blank counter SHALL be loaded with BLANK_CYCLES on every tick edge and SHALL decrement by 1 per enabled cycle while nonzero.
REQ-017 blank SHALL equal (blank counter != 0) OR (enable=0); column_n SHALL be 8'hFF when blank=1, else all ones except bit[select]=0.
REQ-018 blank and column_n SHALL be decoded only from registered state and enable, with no other combinational path from inputs.
REQ-019 While enable=0, prescaler SHALL clear to 0, select and blank counter SHALL hold, and no tick or frame_start SHALL occur.
REQ-020 When enable returns to 1, the channel SHALL restart with a full DIV_VALUE-cycle dwell from prescaler=0.
REQ-021 With BLANK_CYCLES=0, blank SHALL be 0 whenever enable=1, and column_n SHALL switch on the same edge as select.

Reset
REQ-022 While reset_n=0, the module SHALL asynchronously force prescaler=0, select=3'd0, blank counter=BLANK_CYCLES, frame_start=0, column_n=8'hFF, blank=1.
REQ-023 Reset assertion mid-dwell or mid-blank SHALL abort the scan immediately; no partial pulse SHALL remain after release.
REQ-024 After reset_n rises, the first scan SHALL begin on channel 0 and SHALL blank for BLANK_CYCLES enabled cycles first.

Verification
REQ-025 Bench SHALL cover basic scan: DIV_VALUE=4, BLANK_CYCLES=1, last_index=7, enable=1 from reset release -> column_n=8'hFF for 1 cycle, then 8'hFE, select=1 after edge 4, column_n=8'hFF for 1 cycle, then 8'hFD; select sequence 0..7,0 with a period of 4 cycles per channel.
REQ-026 Bench SHALL cover wrap with frame_start: last_index=2 -> select 0,1,2,0; frame_start high exactly 1 cycle after each 2->0 transition, every 12 cycles.
REQ-027 Bench SHALL cover shrinking last_index: last_index changes 7->3 while select=5 -> next tick gives select=0 and a frame_start pulse; the following scan covers 0..3.
REQ-028 Bench SHALL cover pause: enable=0 for 10 cycles mid-dwell on select=2 -> column_n=8'hFF, blank=1, select stays 2; after enable=1, select=2 is held for exactly 4 cycles before advancing to 3.
REQ-029 Bench SHALL cover asynchronous reset: reset_n pulled low between clock edges while select=6 -> select=0, column_n=8'hFF, blank=1 before the next edge; the run resumes per REQ-024.
REQ-030 Bench SHALL cover the degenerate case: BLANK_CYCLES=0, last_index=0 -> column_n constant 8'hFE, blank=0, frame_start pulsing once every 4 cycles.
